// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding,
// default timing parameters and a small index helper.
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    localparam int DEF_SCAN_DIV     = 300000;
    localparam int DEF_DEB_TICKS    = 4;
    localparam int DEF_REPEAT_TICKS = 100;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Index of the lowest-numbered bit that is low (0 when none is low).
    function automatic logic [1:0] lowest_low(input logic [3:0] bits_n);
        lowest_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!bits_n[i]) begin
                lowest_low = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Consumer-side bundle of the keypad scanner: assembled byte with
// valid/ready handshake, live preview of the byte being typed and
// the overrun pulse.
interface keypad_scan_if;

    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] preview;
    logic       overrun;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready,
        output preview,
        output overrun
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready,
        input  preview,
        input  overrun
    );

endinterface

// File: rtl/keypad_debounce.sv
// Row synchronizer plus debounce counter. The counter measures how many
// consecutive scan ticks the selected row has held the wanted level and
// flags the tick on which that run reaches DEB_TICKS.
module keypad_debounce
    import keypad_scan_pkg::*;
#(
    parameter int DEB_TICKS = DEF_DEB_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    input  logic       tick,
    input  logic       clear,
    input  logic [1:0] sel_row,
    input  logic       want_low,
    output logic [3:0] row_sync_n,
    output logic       done
);

    localparam int             CW   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DEB_TICKS - 1);

    logic [3:0]    meta_q;
    logic [3:0]    sync_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;
    logic          level_ok;

    assign row_sync_n = sync_q;
    assign level_ok   = want_low ? ~sync_q[sel_row] : sync_q[sel_row];

    // Count consecutive ticks at the wanted level; a wrong-level tick restarts the run.
    always_comb begin
        cnt_d = cnt_q;
        done  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            if (!level_ok) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                cnt_d = '0;
                done  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous rows, idle level is released (high).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
            cnt_q  <= '0;
        end else begin
            meta_q <= row_n;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column scan, press/release debounce FSM and
// two-nibble byte assembly with a valid/ready output.
// Optional feature: define KEYPAD_REPEAT_EN to re-accept a held key
// every REPEAT_TICKS scan ticks.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int DEB_TICKS    = DEF_DEB_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row_n,
    output logic [3:0]       col_n,
    keypad_scan_if.master    bus
);

    localparam int            PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);

    if (SCAN_DIV < 1 || DEB_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
        $error("keypad_scan: SCAN_DIV, DEB_TICKS and REPEAT_TICKS must be at least 1");
    end

    scan_state_t   state_d, state_q;
    logic [PW-1:0] pre_d, pre_q;
    logic [3:0]    col_d, col_q;
    logic [1:0]    row_d, row_q;
    logic [1:0]    ccol_d, ccol_q;
    logic          phase_d, phase_q;
    logic [7:0]    preview_d, preview_q;
    logic [7:0]    data_out_d, data_out_q;
    logic          data_valid_d, data_valid_q;
    logic          load_d, load_q;
    logic          overrun_d, overrun_q;
    logic          tick;
    logic          accept;
    logic          deb_done;
    logic [3:0]    row_sync_n;
    logic          cap_high;
    logic          busy;
    logic          handshake;
    logic [3:0]    key;
`ifdef KEYPAD_REPEAT_EN
    localparam int            RW       = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0] rep_d, rep_q;
`endif

    assign tick      = (pre_q == PLAST);
    assign pre_d     = tick ? '0 : pre_q + 1'b1;
    assign cap_high  = row_sync_n[row_q];
    assign key       = {row_q, ccol_q};
    assign handshake = data_valid_q & bus.data_ready;
    assign busy      = data_valid_q & ~bus.data_ready;

    assign col_n          = col_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.preview    = preview_q;
    assign bus.overrun    = overrun_q;

    keypad_debounce #(
        .DEB_TICKS (DEB_TICKS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .row_n      (row_n),
        .tick       (tick),
        .clear      ((state_q == ST_SCAN) || (state_q == ST_HELD)),
        .sel_row    (row_q),
        .want_low   (state_q != ST_RELEASE),
        .row_sync_n (row_sync_n),
        .done       (deb_done)
    );

    // Scan/debounce FSM next state; everything advances only on scan ticks.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ccol_d  = ccol_q;
        accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = (state_q == ST_HELD) ? rep_q : '0;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_sync_n != 4'hF) begin
                        row_d   = lowest_low(row_sync_n);
                        ccol_d  = lowest_low(col_q);
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = {col_q[2:0], col_q[3]};
                    end
                end
                ST_DEBOUNCE: begin
                    if (cap_high) begin
                        state_d = ST_SCAN;
                    end else if (deb_done) begin
                        accept  = 1'b1;
                        state_d = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (cap_high) begin
                        state_d = ST_RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_q == REP_LAST) begin
                        accept = 1'b1;
                        rep_d  = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (!cap_high) begin
                        state_d = ST_HELD;
                    end else if (deb_done) begin
                        state_d = ST_SCAN;
                        col_d   = {col_q[2:0], col_q[3]};
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // Byte assembly: the handshake is resolved before a same-cycle key is judged.
    always_comb begin
        preview_d    = preview_q;
        phase_d      = phase_q;
        load_d       = 1'b0;
        overrun_d    = 1'b0;
        data_out_d   = load_q ? preview_q : data_out_q;
        data_valid_d = load_q ? 1'b1 : (handshake ? 1'b0 : data_valid_q);
        if (accept) begin
            if (busy) begin
                overrun_d = 1'b1;
            end else if (!phase_q) begin
                preview_d = {key, 4'h0};
                phase_d   = 1'b1;
            end else begin
                preview_d = {preview_q[7:4], key};
                phase_d   = 1'b0;
                load_d    = 1'b1;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_SCAN;
            pre_q        <= '0;
            col_q        <= COL_RESET;
            row_q        <= 2'd0;
            ccol_q       <= 2'd0;
            phase_q      <= 1'b0;
            preview_q    <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            load_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ccol_q       <= ccol_d;
            phase_q      <= phase_d;
            preview_q    <= preview_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            load_q       <= load_d;
            overrun_q    <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q        <= rep_d;
`endif
        end
    end

endmodule
